// File: rtl/wakeup_delay_pipe.sv
// Per-lane delay line turning issued micro-ops into wakeup broadcasts L cycles later.
// Slot k of a lane holds the op whose broadcast happens k cycles from now.
module wakeup_delay_pipe #(
  parameter int unsigned ISSUE_WIDTH       = 2,
  parameter int unsigned MAX_LATENCY       = 4,
  parameter int unsigned REG_NUM_BIT_WIDTH = 7,
  localparam int unsigned LAT_W            = $clog2(MAX_LATENCY + 1)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        flush,
  input  logic [ISSUE_WIDTH-1:0]                      issue,
  input  logic [ISSUE_WIDTH-1:0]                      issueDstValid,
  input  logic [ISSUE_WIDTH-1:0][REG_NUM_BIT_WIDTH-1:0] issueDstRegNum,
  input  logic [ISSUE_WIDTH-1:0][LAT_W-1:0]           issueLatency,
  output logic [ISSUE_WIDTH-1:0][MAX_LATENCY-1:0]     issueSlotFree,
  output logic [ISSUE_WIDTH-1:0]                      wakeup,
  output logic [ISSUE_WIDTH-1:0]                      wakeupDstValid,
  output logic [ISSUE_WIDTH-1:0][REG_NUM_BIT_WIDTH-1:0] wakeupDstRegNum,
  output logic                                        errCollision
);

  logic [ISSUE_WIDTH-1:0][MAX_LATENCY-1:0]                        valid_q, valid_d;
  logic [ISSUE_WIDTH-1:0][MAX_LATENCY-1:0]                        dst_q, dst_d;
  logic [ISSUE_WIDTH-1:0][MAX_LATENCY-1:0][REG_NUM_BIT_WIDTH-1:0] reg_q, reg_d;
  logic                                                           err_q, err_d;
  logic [ISSUE_WIDTH-1:0]                                         legal;
  logic [ISSUE_WIDTH-1:0]                                         busy;

  // Shift every lane one slot, then drop accepted issues into slot L-1
  always_comb begin
    valid_d = '0;
    dst_d   = '0;
    reg_d   = '0;
    err_d   = err_q;
    legal   = '0;
    busy    = '0;
    for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
      for (int k = 0; k < int'(MAX_LATENCY) - 1; k++) begin
        valid_d[i][k] = valid_q[i][k+1];
        dst_d[i][k]   = dst_q[i][k+1];
        reg_d[i][k]   = reg_q[i][k+1];
      end
      legal[i] = (issueLatency[i] != '0) && (issueLatency[i] <= LAT_W'(MAX_LATENCY));
      // A latency of MAX_LATENCY targets the always-empty slot beyond the array
      for (int k = 1; k < int'(MAX_LATENCY); k++) begin
        if (issueLatency[i] == LAT_W'(k)) busy[i] = valid_q[i][k];
      end
      if (issue[i] && !flush) begin
        if (legal[i] && !busy[i]) begin
          for (int k = 0; k < int'(MAX_LATENCY); k++) begin
            if (issueLatency[i] == LAT_W'(k + 1)) begin
              valid_d[i][k] = 1'b1;
              dst_d[i][k]   = issueDstValid[i];
              reg_d[i][k]   = issueDstRegNum[i];
            end
          end
        end else begin
          err_d = 1'b1;
        end
      end
    end
    if (flush) begin
      valid_d = '0;
      dst_d   = '0;
      reg_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dst_q   <= '0;
      reg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dst_q   <= dst_d;
      reg_q   <= reg_d;
      err_q   <= err_d;
    end
  end

  // Broadcasts come straight from slot 0; slot availability looks one slot ahead
  always_comb begin
    wakeup          = '0;
    wakeupDstValid  = '0;
    wakeupDstRegNum = '0;
    issueSlotFree   = '0;
    for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
      wakeup[i]          = valid_q[i][0];
      wakeupDstValid[i]  = dst_q[i][0];
      wakeupDstRegNum[i] = reg_q[i][0];
      for (int k = 0; k < int'(MAX_LATENCY) - 1; k++) begin
        issueSlotFree[i][k] = !valid_q[i][k+1];
      end
      issueSlotFree[i][MAX_LATENCY-1] = 1'b1;
    end
  end

  assign errCollision = err_q;

endmodule

// File: tb/tb_wakeup_delay_pipe.sv
// Scoreboard bench for wakeup_delay_pipe: expected broadcasts are queued by due cycle
// at issue time and retired when that cycle's outputs are sampled.
module tb_wakeup_delay_pipe;

  localparam int unsigned IW  = 2;
  localparam int unsigned ML  = 4;
  localparam int unsigned RW  = 7;
  localparam int unsigned LW  = $clog2(ML + 1);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     flush;
  logic [IW-1:0]            issue;
  logic [IW-1:0]            issueDstValid;
  logic [IW-1:0][RW-1:0]    issueDstRegNum;
  logic [IW-1:0][LW-1:0]    issueLatency;
  logic [IW-1:0][ML-1:0]    issueSlotFree;
  logic [IW-1:0]            wakeup;
  logic [IW-1:0]            wakeupDstValid;
  logic [IW-1:0][RW-1:0]    wakeupDstRegNum;
  logic                     errCollision;

  wakeup_delay_pipe #(
    .ISSUE_WIDTH(IW), .MAX_LATENCY(ML), .REG_NUM_BIT_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue(issue), .issueDstValid(issueDstValid),
    .issueDstRegNum(issueDstRegNum), .issueLatency(issueLatency),
    .issueSlotFree(issueSlotFree), .wakeup(wakeup),
    .wakeupDstValid(wakeupDstValid), .wakeupDstRegNum(wakeupDstRegNum),
    .errCollision(errCollision)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int lane;
    bit dv;
    int rn;
  } ent_t;

  ent_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   err_exp = 1'b0;
  bit   flushing = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic bit pending(input int lane, input int due);
    foreach (sb[j]) if (sb[j].lane == lane && sb[j].due == due) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outputs();
    for (int l = 0; l < int'(IW); l++) begin
      bit w = 1'b0;
      bit dv = 1'b0;
      int rn = 0;
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].lane == l && sb[j].due == cyc) begin
          w = 1'b1; dv = sb[j].dv; rn = sb[j].rn;
          sb.delete(j);
        end
      end
      check($sformatf("wakeup%0d", l), 32'(wakeup[l]), 32'(w));
      check($sformatf("dstvalid%0d", l), 32'(wakeupDstValid[l]), 32'(dv));
      check($sformatf("regnum%0d", l), 32'(wakeupDstRegNum[l]), 32'(rn));
      for (int L = 1; L <= int'(ML); L++) begin
        bit f = (L == int'(ML)) ? 1'b1 : !pending(l, cyc + L);
        check($sformatf("slotfree%0d_L%0d", l, L), 32'(issueSlotFree[l][L-1]), 32'(f));
      end
    end
    check("errCollision", 32'(errCollision), 32'(err_exp));
  endtask

  // Advance one clock, clear per-cycle stimulus and compare the new cycle's outputs
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    flush = 1'b0;
    flushing = 1'b0;
    issue = '0;
    issueDstValid = '0;
    issueDstRegNum = '0;
    issueLatency = '0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue_op(input int lane, input int lat, input bit dv, input int rn);
    issue[lane] = 1'b1;
    issueDstValid[lane] = dv;
    issueDstRegNum[lane] = RW'(rn);
    issueLatency[lane] = LW'(lat);
    if (rst || flushing) return;
    if (lat >= 1 && lat <= int'(ML) && !pending(lane, cyc + lat))
      sb.push_back('{due: cyc + lat, lane: lane, dv: dv, rn: rn});
    else
      err_exp = 1'b1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    flushing = 1'b1;
    sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    err_exp = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; issue = '0; issueDstValid = '0;
    issueDstRegNum = '0; issueLatency = '0;
    // reset state
    do_reset(); tick();
    do_reset(); tick();

    // latency sweep on lane 0
    for (int L = 1; L <= int'(ML); L++) begin
      issue_op(0, L, 1'b1, 5);
      tick();
      idle(L + 1);
    end

    // back-to-back on lane 1: later ops land on the occupied cycle and are dropped
    issue_op(1, 3, 1'b1, 20); tick();
    check("b2b_free_L2", 32'(issueSlotFree[1][1]), 32'(0));
    issue_op(1, 2, 1'b1, 21); tick();
    issue_op(1, 1, 1'b1, 22); tick();
    idle(4);
    do_reset(); tick();

    // parallel lanes, same latency
    issue_op(0, 2, 1'b1, 10);
    issue_op(1, 2, 1'b1, 11);
    tick(); idle(3);

    // op without destination
    issue_op(0, 1, 1'b0, 7); tick(); idle(2);

    // flush kills the pending op and discards the issue in the flush cycle
    issue_op(0, 4, 1'b1, 30); tick();
    do_flush();
    issue_op(0, 1, 1'b1, 31); tick();
    idle(5);

    // illegal latencies on lane 0 while lane 1 proceeds
    issue_op(0, 0, 1'b1, 50);
    issue_op(1, 1, 1'b1, 51); tick();
    issue_op(0, 5, 1'b1, 52); tick();
    issue_op(0, 7, 1'b1, 53); tick();
    idle(2);

    // reset mid-flight with three ops pending; issues in the reset cycle are ignored
    issue_op(0, 4, 1'b1, 40);
    issue_op(1, 3, 1'b1, 41); tick();
    issue_op(0, 2, 1'b1, 42); tick();
    do_reset();
    issue_op(1, 1, 1'b1, 43); tick();
    idle(6);

    // random traffic with occasional flushes
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) do_flush();
      for (int l = 0; l < int'(IW); l++)
        if ($urandom_range(0, 1) == 1)
          issue_op(l, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 127)));
      tick();
    end
    idle(ML + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
